// File: rtl/vdp_sprite_meta_dma.sv
// Sprite metadata write sequencer: host writes always win, DMA words copied from a packed x/y/g table wait in a one-word buffer.
// Define VDP_SPRITE_DMA_HIDE_UNUSED_EN to add a FILL pass that hides the sprites the DMA did not copy.
module vdp_sprite_meta_dma #(
   parameter int unsigned SOURCE_AW = 16,
   parameter logic [15:0] HIDDEN_Y  = 16'h01E0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 host_write_en,
   input  logic [2:0]           host_block_select,
   input  logic [7:0]           host_address,
   input  logic [15:0]          host_write_data,
   input  logic                 dma_start,
   input  logic                 dma_abort,
   input  logic [SOURCE_AW-1:0] dma_source_base,
   input  logic [8:0]           dma_count,
   output logic                 src_read_en,
   output logic [SOURCE_AW-1:0] src_read_address,
   input  logic [15:0]          src_read_data,
   input  logic                 src_data_valid,
   output logic [7:0]           meta_address,
   output logic [15:0]          meta_write_data,
   output logic [2:0]           meta_block_select,
   output logic                 meta_we,
   output logic                 dma_busy,
   output logic                 dma_done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] FILL  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [SOURCE_AW-1:0] srcAddr_q, srcAddr_d;
   logic [8:0]           count_q, count_d;
   logic [8:0]           spriteId_q, spriteId_d;
   logic [1:0]           wordIdx_q, wordIdx_d;
   logic [15:0]          pendData_q, pendData_d;
   logic [7:0]           metaAddr_q, metaAddr_d;
   logic [15:0]          metaData_q, metaData_d;
   logic [2:0]           metaSel_q, metaSel_d;
   logic                 metaWe_q, metaWe_d;
   logic                 done_q, done_d;

   logic [8:0] effCount;
   logic [2:0] wordSel;
   logic       dmaReq;
   logic       dmaGrant;
   logic       lastWord;

   always_comb begin
      effCount = (dma_count > 9'd256) ? 9'd256 : dma_count;
      case (wordIdx_q)
         2'd0:    wordSel = 3'b001;
         2'd1:    wordSel = 3'b010;
         default: wordSel = 3'b100;
      endcase
      dmaReq   = (state_q == WRITE) || (state_q == FILL);
      dmaGrant = dmaReq && !host_write_en;
      lastWord = (wordIdx_q == 2'd2) && ((spriteId_q + 9'd1) == count_q);
   end

   // One grant per cycle into the registered meta port; the host is never stalled.
   always_comb begin
      metaWe_d   = host_write_en || dmaGrant;
      metaAddr_d = metaAddr_q;
      metaData_d = metaData_q;
      metaSel_d  = metaSel_q;
      if (host_write_en) begin
         metaAddr_d = host_address;
         metaData_d = host_write_data;
         metaSel_d  = host_block_select;
      end else if (dmaGrant) begin
         metaAddr_d = spriteId_q[7:0];
         metaData_d = (state_q == FILL) ? HIDDEN_Y : pendData_q;
         metaSel_d  = (state_q == FILL) ? 3'b010 : wordSel;
      end
   end

   always_comb begin
      state_d    = state_q;
      srcAddr_d  = srcAddr_q;
      count_d    = count_q;
      spriteId_d = spriteId_q;
      wordIdx_d  = wordIdx_q;
      pendData_d = pendData_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (dma_start) begin
               if (effCount == 9'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = READ;
                  srcAddr_d  = dma_source_base;
                  count_d    = effCount;
                  spriteId_d = 9'd0;
                  wordIdx_d  = 2'd0;
               end
            end
         end
         READ: begin
            if (src_data_valid) begin
               pendData_d = src_read_data;
               srcAddr_d  = srcAddr_q + SOURCE_AW'(1);
               state_d    = WRITE;
            end
         end
         WRITE: begin
            if (dmaGrant) begin
               if (wordIdx_q == 2'd2) begin
                  wordIdx_d  = 2'd0;
                  spriteId_d = spriteId_q + 9'd1;
               end else begin
                  wordIdx_d = wordIdx_q + 2'd1;
               end
               if (lastWord) begin
`ifdef VDP_SPRITE_DMA_HIDE_UNUSED_EN
                  if (count_q == 9'd256) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = FILL;
                  end
`else
                  state_d = IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  state_d = READ;
               end
            end
         end
         default: begin
            if (dmaGrant) begin
               spriteId_d = spriteId_q + 9'd1;
               if (spriteId_q == 9'd255) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase
      // Abort wins over any transition but leaves the meta grant of this cycle intact.
      if (dma_abort && (state_q != IDLE)) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         srcAddr_q  <= '0;
         count_q    <= '0;
         spriteId_q <= '0;
         wordIdx_q  <= '0;
         pendData_q <= '0;
         metaAddr_q <= '0;
         metaData_q <= '0;
         metaSel_q  <= '0;
         metaWe_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         srcAddr_q  <= srcAddr_d;
         count_q    <= count_d;
         spriteId_q <= spriteId_d;
         wordIdx_q  <= wordIdx_d;
         pendData_q <= pendData_d;
         metaAddr_q <= metaAddr_d;
         metaData_q <= metaData_d;
         metaSel_q  <= metaSel_d;
         metaWe_q   <= metaWe_d;
         done_q     <= done_d;
      end
   end

   assign src_read_en       = (state_q == READ);
   assign src_read_address  = srcAddr_q;
   assign meta_address      = metaAddr_q;
   assign meta_write_data   = metaData_q;
   assign meta_block_select = metaSel_q;
   assign meta_we           = metaWe_q;
   assign dma_busy          = (state_q != IDLE);
   assign dma_done          = done_q;

endmodule

// File: tb/tb_vdp_sprite_meta_dma.sv
// Scoreboard bench for vdp_sprite_meta_dma: host and DMA expectations queued at stimulus time, popped as meta writes emerge.
module tb_vdp_sprite_meta_dma;

   localparam int SOURCE_AW = 16;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 host_write_en;
   logic [2:0]           host_block_select;
   logic [7:0]           host_address;
   logic [15:0]          host_write_data;
   logic                 dma_start;
   logic                 dma_abort;
   logic [SOURCE_AW-1:0] dma_source_base;
   logic [8:0]           dma_count;
   logic                 src_read_en;
   logic [SOURCE_AW-1:0] src_read_address;
   logic [15:0]          src_read_data;
   logic                 src_data_valid;
   logic [7:0]           meta_address;
   logic [15:0]          meta_write_data;
   logic [2:0]           meta_block_select;
   logic                 meta_we;
   logic                 dma_busy;
   logic                 dma_done;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
      logic [2:0]  sel;
   } metaWrite_t;

   metaWrite_t hostQ[$];
   metaWrite_t dmaQ[$];

   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   doneCount = 0;
   int   doneCycle = 0;
   int   dmaWeCount = 0;
   int   lastDmaCycle = 0;
   int   readCount = 0;
   logic hostAtEdge = 1'b0;

   vdp_sprite_meta_dma #(.SOURCE_AW(SOURCE_AW), .HIDDEN_Y(16'h01E0)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .host_write_en(host_write_en),
      .host_block_select(host_block_select),
      .host_address(host_address),
      .host_write_data(host_write_data),
      .dma_start(dma_start),
      .dma_abort(dma_abort),
      .dma_source_base(dma_source_base),
      .dma_count(dma_count),
      .src_read_en(src_read_en),
      .src_read_address(src_read_address),
      .src_read_data(src_read_data),
      .src_data_valid(src_data_valid),
      .meta_address(meta_address),
      .meta_write_data(meta_write_data),
      .meta_block_select(meta_block_select),
      .meta_we(meta_we),
      .dma_busy(dma_busy),
      .dma_done(dma_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] srcWord(input logic [15:0] a);
      return a ^ 16'h5A5A ^ {a[7:0], 8'h00};
   endfunction

   // Source RAM answers one cycle after it sees a request and drops valid once the read is consumed.
   always @(negedge clk) begin
      if (src_read_en === 1'b1 && src_data_valid == 1'b0) begin
         src_data_valid = 1'b1;
         src_read_data  = srcWord(src_read_address);
         readCount++;
      end else begin
         src_data_valid = 1'b0;
      end
   end

   always @(posedge clk) hostAtEdge <= host_write_en & reset_n;

   // A host strobe at an edge must show up on the meta port after it; any other meta write is a DMA word.
   always @(negedge clk) begin
      metaWrite_t got, exp;
      cycle++;
      got = '{addr: meta_address, data: meta_write_data, sel: meta_block_select};
      if (dma_done === 1'b1) begin
         doneCount++;
         doneCycle = cycle;
         checks++;
         if (dma_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_with_done: dma_busy=%b required 0", dma_busy);
         end
      end
      if (hostAtEdge) begin
         checks++;
         if (meta_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL host_write_missing: meta_we=%b required 1", meta_we);
         end else if (hostQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL host_queue_empty: got %h required none", got);
         end else begin
            exp = hostQ.pop_front();
            if (got !== exp) begin
               errors++;
               $display("[TB] FAIL host_write: got %h required %h", got, exp);
            end
         end
      end else if (meta_we === 1'b1) begin
         dmaWeCount++;
         lastDmaCycle = cycle;
         checks++;
         if (dmaQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_dma_write: got %h required no write", got);
         end else begin
            exp = dmaQ.pop_front();
            if (got !== exp) begin
               errors++;
               $display("[TB] FAIL dma_write: got %h required %h", got, exp);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "[TB] timeout");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pushDma(input logic [15:0] base, input int firstWord, input int numWords);
      for (int w = firstWord; w < firstWord + numWords; w++) begin
         logic [15:0] a;
         a = base + 16'(w);
         dmaQ.push_back('{addr: 8'(w / 3), data: srcWord(a), sel: 3'(1 << (w % 3))});
      end
   endtask

   task automatic pulseStart(input logic [15:0] base, input logic [8:0] cnt);
      dma_source_base = base;
      dma_count       = cnt;
      dma_start       = 1'b1;
      step();
      dma_start = 1'b0;
   endtask

   task automatic test_reset();
      int d0;
      reset_n = 1'b0;
      step();
      checks++;
      if ({src_read_en, src_read_address, meta_address, meta_write_data, meta_block_select,
           meta_we, dma_busy, dma_done} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: busy=%b rd=%b we=%b done=%b required all 0",
                  dma_busy, src_read_en, meta_we, dma_done);
      end
      reset_n = 1'b1;
      repeat (2) step();
      d0 = doneCount;
      pulseStart(16'h0800, 9'd4);
      checks++;
      if (src_read_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_setup_read: src_read_en=%b required 1", src_read_en);
      end
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({src_read_en, src_read_address, meta_we, dma_busy, dma_done} !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset: rd=%b addr=%h we=%b busy=%b done=%b required all 0",
                  src_read_en, src_read_address, meta_we, dma_busy, dma_done);
      end
      repeat (2) step();
      reset_n = 1'b1;
      repeat (10) step();
      checks++;
      if (dma_busy !== 1'b0 || doneCount != d0) begin
         errors++;
         $display("[TB] FAIL reset_abandon: busy=%b dones=%0d required busy 0 dones %0d",
                  dma_busy, doneCount, d0);
      end
   endtask

   task automatic test_basic();
      int d0, w0, r0;
      d0 = doneCount; w0 = dmaWeCount; r0 = readCount;
      pushDma(16'h0100, 0, 6);
      pulseStart(16'h0100, 9'd2);
      for (int i = 0; i < 200 && doneCount == d0; i++) step();
      repeat (3) step();
      checks++;
      if (doneCount != d0 + 1) begin
         errors++;
         $display("[TB] FAIL basic_done: got %0d dones required 1", doneCount - d0);
      end
      checks++;
      if (dmaWeCount - w0 != 6 || dmaQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL basic_writes: got %0d writes (%0d left) required 6", dmaWeCount - w0, dmaQ.size());
      end
      checks++;
      if (readCount - r0 != 6 || dma_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_reads: got %0d reads busy=%b required 6 reads busy 0", readCount - r0, dma_busy);
      end
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = doneCount;
      pushDma(16'h0200, 0, 3);
      pulseStart(16'h0200, 9'd1);
      for (int i = 0; i < 20 && src_data_valid !== 1'b1; i++) step();
      for (int h = 0; h < 5; h++) begin
         host_write_en     = 1'b1;
         host_address      = 8'(8'h40 + h);
         host_write_data   = 16'hC000 + 16'(h * 16'h0111);
         host_block_select = 3'(1 << (h % 3));
         hostQ.push_back('{addr: host_address, data: host_write_data, sel: host_block_select});
         step();
      end
      host_write_en = 1'b0;
      step();
      checks++;
      if (meta_we !== 1'b1 || meta_block_select !== 3'b001 || meta_address !== 8'h00 ||
          meta_write_data !== srcWord(16'h0200)) begin
         errors++;
         $display("[TB] FAIL pending_after_host: we=%b sel=%b addr=%h data=%h required 1 001 00 %h",
                  meta_we, meta_block_select, meta_address, meta_write_data, srcWord(16'h0200));
      end
      for (int i = 0; i < 100 && doneCount == d0; i++) step();
      step();
      checks++;
      if (doneCount != d0 + 1 || dmaQ.size() != 0 || hostQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL back_to_back_end: dones=%0d dmaLeft=%0d hostLeft=%0d required 1 0 0",
                  doneCount - d0, dmaQ.size(), hostQ.size());
      end
   endtask

   task automatic test_count_edges();
      int d0, w0, r0;
      logic sawRead;
      d0 = doneCount; w0 = dmaWeCount; r0 = readCount;
      sawRead = 1'b0;
      pulseStart(16'h0300, 9'd0);
      checks++;
      if (dma_done !== 1'b1 || dma_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_count_done: done=%b busy=%b required 1 0", dma_done, dma_busy);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         sawRead = sawRead | src_read_en;
      end
      checks++;
      if (doneCount != d0 + 1 || sawRead !== 1'b0 || dmaWeCount != w0 || readCount != r0) begin
         errors++;
         $display("[TB] FAIL zero_count_quiet: dones=%0d read=%b writes=%0d required 1 0 0",
                  doneCount - d0, sawRead, dmaWeCount - w0);
      end
      d0 = doneCount; w0 = dmaWeCount; r0 = readCount;
      pushDma(16'hFF00, 0, 768);
      pulseStart(16'hFF00, 9'd300);
      for (int i = 0; i < 4000 && doneCount == d0; i++) step();
      step();
      checks++;
      if (readCount - r0 != 768) begin
         errors++;
         $display("[TB] FAIL clamp_reads: got %0d required 768", readCount - r0);
      end
      checks++;
      if (doneCount != d0 + 1 || dmaWeCount - w0 != 768 || dmaQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL clamp_writes: dones=%0d writes=%0d required 1 768", doneCount - d0, dmaWeCount - w0);
      end
   endtask

   task automatic test_abort();
      int d0;
      logic found;
      d0 = doneCount;
      found = 1'b0;
      pushDma(16'h0300, 0, 10);
      pulseStart(16'h0300, 9'd8);
      for (int i = 0; i < 200; i++) begin
         if (src_read_en === 1'b1 && src_read_address === 16'h030A) begin
            found = 1'b1;
            break;
         end
         step();
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL abort_reach_y3: read of 030A not seen, required seen");
      end
      dma_abort = 1'b1;
      step();
      dma_abort = 1'b0;
      checks++;
      if (src_read_en !== 1'b0 || dma_busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_stop: rd=%b busy=%b required 0 0", src_read_en, dma_busy);
      end
      repeat (15) step();
      checks++;
      if (doneCount != d0 || dmaQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL abort_quiet: dones=%0d left=%0d required 0 0", doneCount - d0, dmaQ.size());
      end
      pushDma(16'h0400, 0, 3);
      pulseStart(16'h0400, 9'd1);
      for (int i = 0; i < 100 && doneCount == d0; i++) step();
      step();
      checks++;
      if (doneCount != d0 + 1 || dmaQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL abort_restart: dones=%0d left=%0d required 1 0", doneCount - d0, dmaQ.size());
      end
   endtask

   task automatic test_tail();
      int d0, w0, expWrites;
      d0 = doneCount; w0 = dmaWeCount;
      expWrites = 762;
      pushDma(16'h1000, 0, 762);
`ifdef VDP_SPRITE_DMA_HIDE_UNUSED_EN
      for (int id = 254; id < 256; id++)
         dmaQ.push_back('{addr: 8'(id), data: 16'h01E0, sel: 3'b010});
      expWrites = 764;
`endif
      pulseStart(16'h1000, 9'd254);
      for (int i = 0; i < 4000 && doneCount == d0; i++) step();
      step();
      checks++;
      if (doneCount != d0 + 1 || dmaWeCount - w0 != expWrites || dmaQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL tail_writes: dones=%0d writes=%0d left=%0d required 1 %0d 0",
                  doneCount - d0, dmaWeCount - w0, dmaQ.size(), expWrites);
      end
      checks++;
      if (doneCycle != lastDmaCycle) begin
         errors++;
         $display("[TB] FAIL tail_done_timing: done cycle %0d last write cycle %0d required equal",
                  doneCycle, lastDmaCycle);
      end
   endtask

   initial begin
      reset_n           = 1'b0;
      host_write_en     = 1'b0;
      host_block_select = 3'b000;
      host_address      = 8'h00;
      host_write_data   = 16'h0000;
      dma_start         = 1'b0;
      dma_abort         = 1'b0;
      dma_source_base   = '0;
      dma_count         = 9'd0;
      src_read_data     = 16'h0000;
      src_data_valid    = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_count_edges();
      test_abort();
      test_tail();
      repeat (3) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
